// File: rtl/matrix_stream_packer_pkg.sv
// Shared constants and state encoding for the matrix stream packer.
package matrix_stream_packer_pkg;

    localparam int ELEM_W   = 8;
    localparam int N        = 4;
    localparam int NUM_ELEM = N * N;
    localparam int MAT_W    = NUM_ELEM * ELEM_W;
    localparam int CNT_W    = $clog2(NUM_ELEM + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2
    } state_t;

endpackage

// File: rtl/matrix_stream_packer_if.sv
// Element stream in, packed matrix out, plus status and FSM debug state.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The sender holds valid and its payload steady until that
// edge; ready may be asserted independently of valid.
interface matrix_stream_packer_if
    import matrix_stream_packer_pkg::state_t;
#(
    parameter int ELEM_W = matrix_stream_packer_pkg::ELEM_W,
    parameter int N      = matrix_stream_packer_pkg::N
);
    localparam int NUM_ELEM = N * N;
    localparam int MAT_W    = NUM_ELEM * ELEM_W;
    localparam int CNT_W    = $clog2(NUM_ELEM + 1);

    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;
    logic              in_last;
    logic              abort;
    logic              mat_valid;
    logic              mat_ready;
    logic [MAT_W-1:0]  mat_data;
    logic [CNT_W-1:0]  count;
    logic              err;
    state_t            state;

    modport master (
        output in_valid, in_data, in_last, abort, mat_ready,
        input  in_ready, mat_valid, mat_data, count, err, state
    );

    modport slave (
        input  in_valid, in_data, in_last, abort, mat_ready,
        output in_ready, mat_valid, mat_data, count, err, state
    );

endinterface

// File: rtl/matrix_stream_packer.sv
// Collects N*N signed elements (row-major) into one packed matrix word and
// presents it downstream; framing errors and aborts drop the partial matrix.
module matrix_stream_packer
    import matrix_stream_packer_pkg::state_t,
           matrix_stream_packer_pkg::IDLE,
           matrix_stream_packer_pkg::LOAD,
           matrix_stream_packer_pkg::PRESENT;
#(
    parameter int ELEM_W = matrix_stream_packer_pkg::ELEM_W,
    parameter int N      = matrix_stream_packer_pkg::N
) (
    input  logic                 clk,
    input  logic                 reset,
    matrix_stream_packer_if.slave bus
);

    localparam int NUM_ELEM = N * N;
    localparam int MAT_W    = NUM_ELEM * ELEM_W;
    localparam int CNT_W    = $clog2(NUM_ELEM + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEM - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  count_q;
    logic [MAT_W-1:0]  data_q;
    logic              mat_valid_q;
    logic              in_ready_q;
    logic              err_q;

    logic accept;
    logic handoff;
    logic [CNT_W-1:0] count_d;

    assign accept  = bus.in_valid & in_ready_q;
    assign handoff = mat_valid_q & bus.mat_ready;
    assign count_d = count_q + 1'b1;

    // Single FSM: element capture, framing checks, presentation and handoff.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            data_q      <= '0;
            mat_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (bus.abort) begin
                // Abort beats any accept or handoff in the same cycle.
                state_q     <= IDLE;
                count_q     <= '0;
                mat_valid_q <= 1'b0;
                in_ready_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (accept) begin
                            // First element lands in the top slot; the rest start at zero.
                            data_q <= {bus.in_data, {(MAT_W-ELEM_W){1'b0}}};
                            if (bus.in_last) begin
                                err_q   <= 1'b1;
                                count_q <= '0;
                            end else begin
                                count_q <= CNT_W'(1);
                                state_q <= LOAD;
                            end
                        end
                    end
                    LOAD: begin
                        if (accept) begin
                            for (int k = 1; k < NUM_ELEM; k++) begin
                                if (count_q == CNT_W'(k)) begin
                                    data_q[MAT_W-1-ELEM_W*k -: ELEM_W] <= bus.in_data;
                                end
                            end
                            if ((count_q == LAST_IDX) && bus.in_last) begin
                                state_q     <= PRESENT;
                                count_q     <= count_d;
                                mat_valid_q <= 1'b1;
                                in_ready_q  <= 1'b0;
                            end else if ((count_q == LAST_IDX) || bus.in_last) begin
                                // in_last on the wrong element: drop the matrix.
                                err_q   <= 1'b1;
                                count_q <= '0;
                                state_q <= IDLE;
                            end else begin
                                count_q <= count_d;
                            end
                        end
                    end
                    PRESENT: begin
                        if (handoff) begin
                            state_q     <= IDLE;
                            count_q     <= '0;
                            mat_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        count_q     <= '0;
                        mat_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mat_valid = mat_valid_q;
    assign bus.mat_data  = data_q;
    assign bus.count     = count_q;
    assign bus.err       = err_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_matrix_stream_packer.sv
// Bench for matrix_stream_packer: table of matrices plus abort/reset sequences.
module tb_matrix_stream_packer;
    import matrix_stream_packer_pkg::*;

    localparam int K_SEQ  = 0;
    localparam int K_ONES = 1;
    localparam int K_ID   = 2;
    localparam int K_RAND = 3;
    localparam logic [MAT_W-1:0] SEQ_MAT  = 128'h0102030405060708090A0B0C0D0E0F10;
    localparam logic [MAT_W-1:0] ONES_MAT = {MAT_W{1'b1}};
    localparam logic [MAT_W-1:0] ID_MAT   = 128'h01000000_00010000_00000100_00000001;

    typedef struct {
        int               kind;
        int               last_at;   // index carrying in_last; 16 means never
        int               gap_max;
        int               delay;     // cycles mat_ready stays low while presented
        bit               exp_err;
        logic [MAT_W-1:0] exp_mat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    matrix_stream_packer_if bus ();

    matrix_stream_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;
    int exp_err_total = 0;
    logic [MAT_W-1:0] exp_q[$];
    logic [ELEM_W-1:0] elems[NUM_ELEM];
    vec_t vecs[8];

    task automatic check_mat(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard/monitor: pops expected matrices on handoff, checks stall stability, counts err pulses.
    task automatic monitor();
        logic             prev_hold = 1'b0;
        logic [MAT_W-1:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.err) err_seen++;
                if (prev_hold) begin
                    check_bit("stall_valid", bus.mat_valid, 1'b1);
                    check_mat("stall_data", bus.mat_data, prev_data);
                end
                if (bus.mat_valid && bus.mat_ready && !bus.abort) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_handoff: got %h expected none", bus.mat_data);
                    end else begin
                        check_mat("handoff_data", bus.mat_data, exp_q.pop_front());
                    end
                end
            end
            prev_hold = !reset && !bus.abort && bus.mat_valid && !bus.mat_ready;
            prev_data = bus.mat_data;
        end
    endtask

    // Drives one element from posedge+1 and returns at posedge+1 after it is accepted.
    task automatic drive_elem(input logic [ELEM_W-1:0] d, input logic last);
        int  waited = 0;
        bit  done = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) done = 1;
            @(posedge clk);
            #1;
            waited++;
            if (!done && waited > 50) begin
                n_checks++;
                n_errors++;
                $display("FAIL accept_timeout: got no in_ready expected in_ready within 50 cycles");
                done = 1;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_row(input int last_at, input int gap_max);
        int n;
        n = (last_at > NUM_ELEM - 1) ? NUM_ELEM : last_at + 1;
        for (int k = 0; k < n; k++) begin
            int g;
            g = int'($urandom_range(gap_max, 0));
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            drive_elem(elems[k], k == last_at);
            if (k < n - 1) begin
                check_int("load_count", int'(bus.count), k + 1);
                if (k == 0) check_mat("slot_clear", bus.mat_data, {elems[0], {(MAT_W-ELEM_W){1'b0}}});
            end
        end
    endtask

    task automatic fill_elems(input int kind);
        for (int k = 0; k < NUM_ELEM; k++) begin
            case (kind)
                K_SEQ:   elems[k] = ELEM_W'(k + 1);
                K_ONES:  elems[k] = '1;
                K_ID:    elems[k] = (k % 5 == 0) ? ELEM_W'(1) : '0;
                default: elems[k] = ELEM_W'($urandom_range(255, 0));
            endcase
        end
    endtask

    task automatic run_row(input vec_t v);
        logic [MAT_W-1:0] exp;
        fill_elems(v.kind);
        exp = v.exp_mat;
        if (v.kind == K_RAND) begin
            for (int k = 0; k < NUM_ELEM; k++) exp[MAT_W-1-ELEM_W*k -: ELEM_W] = elems[k];
        end
        bus.mat_ready = (v.delay == 0);
        if (v.exp_err) exp_err_total++;
        else exp_q.push_back(exp);
        send_row(v.last_at, v.gap_max);
        if (v.exp_err) begin
            check_bit("err_pulse", bus.err, 1'b1);
            check_int("err_count", int'(bus.count), 0);
            check_int("err_state", int'(bus.state), int'(IDLE));
            check_bit("err_no_valid", bus.mat_valid, 1'b0);
            @(posedge clk);
            #1;
            check_bit("err_one_cycle", bus.err, 1'b0);
        end else begin
            check_bit("valid_latency", bus.mat_valid, 1'b1);
            check_bit("present_ready", bus.in_ready, 1'b0);
            check_int("present_count", int'(bus.count), NUM_ELEM);
            check_int("present_state", int'(bus.state), int'(PRESENT));
            repeat (v.delay) begin
                @(posedge clk);
                #1;
                check_bit("held_valid", bus.mat_valid, 1'b1);
                check_bit("held_ready", bus.in_ready, 1'b0);
            end
            bus.mat_ready = 1'b1;
            @(posedge clk);
            #1;
            check_bit("post_valid", bus.mat_valid, 1'b0);
            check_int("post_count", int'(bus.count), 0);
            check_bit("post_ready", bus.in_ready, 1'b1);
            check_mat("post_retain", bus.mat_data, exp);
        end
    endtask

    initial begin
        vecs[0] = '{K_SEQ,  15, 0, 0, 1'b0, SEQ_MAT};
        vecs[1] = '{K_ONES, 15, 0, 5, 1'b0, ONES_MAT};
        vecs[2] = '{K_SEQ,   9, 0, 0, 1'b1, '0};
        vecs[3] = '{K_RAND, 15, 0, 0, 1'b0, '0};
        vecs[4] = '{K_ID,   15, 3, 2, 1'b0, ID_MAT};
        vecs[5] = '{K_RAND, 16, 1, 0, 1'b1, '0};
        vecs[6] = '{K_RAND,  0, 0, 0, 1'b1, '0};
        vecs[7] = '{K_SEQ,  15, 2, 1, 1'b0, SEQ_MAT};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.abort     = 1'b0;
        bus.mat_ready = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check_bit("rst_in_ready", bus.in_ready, 1'b1);
        check_bit("rst_mat_valid", bus.mat_valid, 1'b0);
        check_int("rst_count", int'(bus.count), 0);
        check_bit("rst_err", bus.err, 1'b0);
        check_mat("rst_mat_data", bus.mat_data, '0);
        check_int("rst_state", int'(bus.state), int'(IDLE));

        for (int r = 0; r < 8; r++) run_row(vecs[r]);

        // Abort coinciding with the 8th accept.
        fill_elems(K_SEQ);
        bus.mat_ready = 1'b0;
        for (int k = 0; k < 7; k++) drive_elem(elems[k], 1'b0);
        check_int("pre_abort_count", int'(bus.count), 7);
        bus.in_valid = 1'b1;
        bus.in_data  = elems[7];
        bus.abort    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        check_int("abort_count", int'(bus.count), 0);
        check_int("abort_state", int'(bus.state), int'(IDLE));
        check_bit("abort_err", bus.err, 1'b0);
        check_bit("abort_valid", bus.mat_valid, 1'b0);

        // Abort during PRESENT wins over a same-cycle handoff.
        send_row(15, 0);
        check_bit("abort_pres_valid", bus.mat_valid, 1'b1);
        bus.mat_ready = 1'b1;
        bus.abort     = 1'b1;
        @(posedge clk);
        #1;
        bus.abort     = 1'b0;
        bus.mat_ready = 1'b0;
        check_bit("abort_pres_valid_off", bus.mat_valid, 1'b0);
        check_int("abort_pres_count", int'(bus.count), 0);
        check_int("abort_pres_state", int'(bus.state), int'(IDLE));
        check_bit("abort_pres_err", bus.err, 1'b0);

        // Reset during PRESENT discards the matrix.
        fill_elems(K_ONES);
        send_row(15, 0);
        check_bit("rst_pres_valid_on", bus.mat_valid, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_bit("rst_pres_valid", bus.mat_valid, 1'b0);
        check_mat("rst_pres_data", bus.mat_data, '0);
        check_int("rst_pres_count", int'(bus.count), 0);
        check_bit("rst_pres_ready", bus.in_ready, 1'b1);
        check_bit("rst_pres_err", bus.err, 1'b0);

        // Recovery after reset.
        run_row('{K_RAND, 15, 1, 1, 1'b0, '0});

        repeat (2) @(posedge clk);
        #1;
        check_int("scoreboard_empty", exp_q.size(), 0);
        check_int("err_pulse_total", err_seen, exp_err_total);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/matrix_stream_packer.md
MATRIX_STREAM_PACKER -- requirements
Module: matrix_stream_packer

Interface
REQ-001 Parameter ELEM_W, default 8: signed element width in bits.
REQ-002 Parameter N, default 4: matrix dimension; N*N elements per matrix; MAT_W = N*N*ELEM_W = 128.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_data holds a valid element.
REQ-006 in_ready  output  1  block can accept an element this cycle.
REQ-007 in_data  input  ELEM_W  signed element, row-major order.
REQ-008 in_last  input  1  marks the final element of a matrix.
REQ-009 abort  input  1  discard any partial or pending matrix.
REQ-010 mat_valid  output  1  mat_data holds a complete matrix.
REQ-011 mat_ready  input  1  downstream consumer (determinant/arith unit) accepts matrix.
REQ-012 mat_data  output  MAT_W  packed matrix; element k at bits [MAT_W-1-ELEM_W*k -: ELEM_W] (a at [127:120], p at [7:0]).
REQ-013 count  output  5  number of elements accepted into the current matrix, 0..16.
REQ-014 err  output  1  one-cycle pulse on framing error.

Function
REQ-015 State machine SHALL have states IDLE, LOAD, PRESENT.
REQ-016 Element accept SHALL occur on in_valid & in_ready; in_ready = 1 in IDLE and LOAD, 0 in PRESENT.
REQ-017 Accept in IDLE SHALL write element 0, clear all other element slots to 0, set count=1, go to LOAD.
REQ-018 Accept in LOAD SHALL write element at index count, increment count.
REQ-019 Accept of element 15 with in_last=1 SHALL go to PRESENT; mat_valid = 1 in the next cycle (latency 1 after 16th accept).
REQ-020 in_last=1 on an element with index < 15 SHALL pulse err, clear count to 0, return to IDLE, and not assert mat_valid.
REQ-021 in_last=0 on element 15 SHALL pulse err, clear count to 0, return to IDLE, and not assert mat_valid.
REQ-022 In PRESENT, mat_data and mat_valid SHALL stay stable until mat_valid & mat_ready.
REQ-023 Handoff (mat_valid & mat_ready) SHALL go to IDLE next cycle with count=0; mat_data retains last value.
REQ-024 abort SHALL force IDLE, count=0, mat_valid=0 next cycle from any state; abort wins over a same-cycle accept or handoff; no err pulse.
REQ-025 Elements SHALL be stored bit-exact, with no sign extension or saturation.
REQ-026 Back-to-back throughput SHALL be 16 accept cycles plus at least 1 PRESENT cycle per matrix.

Reset
REQ-027 reset SHALL have priority over abort and all handshakes.
REQ-028 reset SHALL set state=IDLE, mat_data=0, count=0, mat_valid=0, err=0; in_ready=1 on the first cycle after reset.
REQ-029 reset asserted mid-LOAD or in PRESENT SHALL discard the matrix without an err pulse.

Structure
REQ-030 Shared package SHALL hold ELEM_W, N, MAT_W and the state enum (IDLE, LOAD, PRESENT).
REQ-031 No sub-module is natural; a single module with one state register, a 5-bit counter and a 128-bit data register.

Verification
REQ-032 Stream 1..16 with in_valid held high, in_last on the 16th, mat_ready=1 -> mat_data = 0x0102...0F10, mat_valid for 1 cycle, one cycle after the 16th accept.
REQ-033 Stream 16 elements of -1 (0xFF), mat_ready=0 for 5 cycles -> mat_data = all ones, stable; in_ready=0 throughout PRESENT.
REQ-034 in_last on the 10th element -> err pulse, count=0, no mat_valid; next full matrix packs correctly with zeroed slots overwritten.
REQ-035 abort in the same cycle as the 8th accept -> count=0, IDLE, no err, no mat_valid.
REQ-036 reset during PRESENT -> mat_valid=0, mat_data=0, count=0 next cycle.
REQ-037 Identity matrix (1 on the diagonal) streamed with random in_valid gaps -> mat_data = 0x01000000_00010000_00000100_00000001.
